// File: rtl/press_judge_if.sv
// Bundle between the LED sweep / switch inputs and the press judge.
// master modport: stimulus side (button, LEDs, switches, step).
// slave modport: judge side (hit/miss pulses, captured LEDs, streak, busy).
interface press_judge_if #(
    parameter int W = 8
);
    logic         BTN;
    logic [W-1:0] LEDS;
    logic [W-1:0] SW;
    logic         STEP;
    logic         HIT;
    logic         MISS;
    logic [W-1:0] CAP_LEDS;
    logic [W-1:0] STREAK;
    logic         BUSY;

    modport master (
        output BTN, LEDS, SW, STEP,
        input  HIT, MISS, CAP_LEDS, STREAK, BUSY
    );

    modport slave (
        input  BTN, LEDS, SW, STEP,
        output HIT, MISS, CAP_LEDS, STREAK, BUSY
    );
endinterface

// File: rtl/press_judge.sv
// Purpose: debounce the player button, capture LEDS/SW on release, judge hit or miss.
// Latency: HIT/MISS rises 3 edges after the debounced falling edge (REL, capture, judge).
// Backpressure: none; one judgement per LED position, extra presses dropped until STEP.
module press_judge #(
    parameter int DB_CYCLES = 500000,
    parameter int W         = 8
) (
    input  logic         CLK,
    input  logic         RST,
    press_judge_if.slave pj
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] JUDGE   = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    logic          sync_a;
    logic          sync_b;
    logic          db;
    logic          db_dly;
    logic [CW-1:0] db_cnt;
    logic          rel;

    logic [1:0]    state;
    logic [W-1:0]  cap_leds;
    logic [W-1:0]  cap_sw;
    logic [W-1:0]  streak;
    logic          hit;
    logic          miss;
    logic          match;

    // Two-flop synchroniser for the raw asynchronous button.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= pj.BTN;
            sync_b <= sync_a;
        end
    end

    // Debounce: the debounced level follows only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            db     <= 1'b0;
            db_cnt <= '0;
        end else if (sync_b != db) begin
            if (db_cnt == DB_LAST) begin
                db     <= sync_b;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Release pulse: one cycle after the debounced level falls 1->0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            db_dly <= 1'b0;
            rel    <= 1'b0;
        end else begin
            db_dly <= db;
            rel    <= db_dly & ~db;
        end
    end

    // Full-width equality; an all-zero capture can never be a hit.
    assign match = (cap_leds == cap_sw) && (cap_leds != '0);

    // Judge FSM: arm on a held button, capture on release, judge once, lock out until STEP.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cap_leds <= '0;
            cap_sw   <= '0;
            streak   <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (db) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    // A STEP in the same cycle as REL is deliberately dropped; capture wins.
                    if (rel) begin
                        cap_leds <= pj.LEDS;
                        cap_sw   <= pj.SW;
                        state    <= JUDGE;
                    end
                end
                JUDGE: begin
                    if (match) begin
                        hit <= 1'b1;
                        if (streak != '1) begin
                            streak <= streak + 1'b1;
                        end
                    end else begin
                        miss   <= 1'b1;
                        streak <= '0;
                    end
                    state <= LOCKOUT;
                end
                LOCKOUT: begin
                    // Presses and releases here are discarded; only the sweep advancing frees us.
                    if (pj.STEP) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pj.HIT      = hit;
    assign pj.MISS     = miss;
    assign pj.CAP_LEDS = cap_leds;
    assign pj.STREAK   = streak;
    assign pj.BUSY     = (state == JUDGE) || (state == LOCKOUT);

endmodule
